mul_wb_buffer: RTL and testbench
================================

// Module: mul_wb_buffer
// PURPOSE
// Sits directly downstream of the pipelined multiplier (MUL_LAT+1 cycles from go to complete).
// Captures every completing result (rob ptr, prf ptr/valid, data) in a DEPTH-entry FIFO.
// Drains the FIFO to the shared writeback/ROB-completion port through a valid/ready handshake.
// The multiplier pipeline cannot stall, so this block grants issue credits upstream; an accepted
// result therefore always has a free slot.
// PARAMETERS
// M_WIDTH   64  result data width (matches multiplier y)
// LG_ROB    6   ROB pointer width
// LG_PRF    7   PRF pointer width
// LG_DEPTH  3   log2 of FIFO depth; DEPTH = 1<<LG_DEPTH, must be >= MUL_LAT+1 for full throughput
// PORTS
// clk          in   1         clock
// reset        in   1         synchronous, active-high reset
// go_in        in   1         multiply issued into multiplier this cycle (same signal as mul go)
// mul_complete in   1         multiplier result valid this cycle
// mul_rob_ptr  in   LG_ROB    ROB pointer of completing result
// mul_prf_val  in   1         result writes the PRF
// mul_prf_ptr  in   LG_PRF    destination PRF pointer
// mul_y        in   M_WIDTH   result data
// can_issue    out  1         credit available; upstream may assert go_in only when 1
// wb_valid     out  1         FIFO head valid
// wb_ready     in   1         writeback port accepts head this cycle
// wb_rob_ptr   out  LG_ROB    head ROB pointer
// wb_prf_val   out  1         head PRF write enable
// wb_prf_ptr   out  LG_PRF    head PRF pointer
// wb_data      out  M_WIDTH   head data
// occupancy    out  LG_DEPTH+1  entries currently held
// err_overflow out  1         sticky protocol-violation flag
// BEHAVIOUR
// - Reset: rd/wr pointers 0, occupancy 0, inflight 0, wb_valid 0, can_issue 1, err_overflow 0;
//   wb_* payload outputs 0. Reset mid-operation discards all entries and credits (multiplier is reset too).
// - Storage: circular buffer, pointers LG_DEPTH+1 bits wide; MSB distinguishes full from empty.
//   Wrap from DEPTH-1 to 0 is seamless.
// - Push: mul_complete=1 writes entry at wr_ptr at the clock edge. No bypass: a result pushed at
//   edge t is presented with wb_valid=1 from t+1 (one-cycle buffer latency minimum).
// - Pop: wb_valid & wb_ready advances rd_ptr at the edge. The head payload is stable while
//   wb_valid & !wb_ready.
// - Simultaneous push+pop: both occur, occupancy unchanged; legal when full (slot freed same
//   edge) and when occupancy==1.
// - Credits: inflight counter (LG_DEPTH+1 bits) +1 on go_in, -1 on mul_complete, unchanged on both.
//   can_issue = (occupancy + inflight) < DEPTH, computed combinationally from registered state only.
// - go_in while can_issue=0, or mul_complete while full with no pop: set err_overflow (sticky until
//   reset). The push is dropped, state is otherwise unchanged, and inflight still decrements.
// - mul_complete with inflight==0 (spurious): set err_overflow; inflight saturates at 0.
// - Payload fields pass through unmodified; wb_prf_val mirrors mul_prf_val of that entry.
// - Ordering strictly FIFO, equal to multiplier completion order.
// TESTING
// 1. Reset, then idle: wb_valid=0, occupancy=0, can_issue=1, err_overflow=0.
// 2. One go, MUL_LAT=4, wb_ready=1: complete rob=5 prf=17 y=0xDEAD at cycle 5 -> wb_valid at cycle 6
//    with same fields, popped; occupancy back to 0.
// 3. wb_ready=0, issue back-to-back: can_issue drops after 8 gos, 8 entries held, no err;
//    raise wb_ready -> drains rob 0..7 in order.
// 4. Full FIFO with push and pop at the same edge: occupancy stays 8, order preserved across
//    pointer wrap (12 entries).
// 5. Force go_in while can_issue=0 / spurious complete -> err_overflow=1, sticky until reset.
// 6. Assert reset with 3 entries and 2 inflight -> next cycle wb_valid=0, occupancy=0, can_issue=1.

Source files
------------

// File: rtl/mul_wb_buffer.sv
// mul_wb_buffer: result FIFO between the non-stallable multiplier pipeline and the
// shared writeback/ROB-completion port. Upstream issue is throttled by credits so that
// every legally issued multiply finds a free slot when it completes.
module mul_wb_buffer #(
  parameter int M_WIDTH  = 64,
  parameter int LG_ROB   = 6,
  parameter int LG_PRF   = 7,
  parameter int LG_DEPTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go_in,
  input  logic                mul_complete,
  input  logic [LG_ROB-1:0]   mul_rob_ptr,
  input  logic                mul_prf_val,
  input  logic [LG_PRF-1:0]   mul_prf_ptr,
  input  logic [M_WIDTH-1:0]  mul_y,
  output logic                can_issue,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [LG_ROB-1:0]   wb_rob_ptr,
  output logic                wb_prf_val,
  output logic [LG_PRF-1:0]   wb_prf_ptr,
  output logic [M_WIDTH-1:0]  wb_data,
  output logic [LG_DEPTH:0]   occupancy,
  output logic                err_overflow
);

  localparam int DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0]   DEPTH_P = (LG_DEPTH+1)'(DEPTH);
  localparam logic [LG_DEPTH+1:0] DEPTH_S = (LG_DEPTH+2)'(DEPTH);

  logic [LG_ROB-1:0]  rob_mem [DEPTH];
  logic               pv_mem  [DEPTH];
  logic [LG_PRF-1:0]  prf_mem [DEPTH];
  logic [M_WIDTH-1:0] y_mem   [DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [LG_DEPTH:0]   wr_ptr, rd_ptr, inflight;
  logic [LG_DEPTH-1:0] wr_idx, rd_idx;
  logic [LG_DEPTH+1:0] credit_sum;
  logic                full, empty, pop, push_ok, go_ok, dec_ok, err_set;

  // Derived status and handshake terms, all from registered state plus inputs.
  always_comb begin
    wr_idx     = wr_ptr[LG_DEPTH-1:0];
    rd_idx     = rd_ptr[LG_DEPTH-1:0];
    occupancy  = wr_ptr - rd_ptr;
    full       = (occupancy == DEPTH_P);
    empty      = (occupancy == '0);
    credit_sum = {1'b0, occupancy} + {1'b0, inflight};
    can_issue  = (credit_sum < DEPTH_S);
    wb_valid   = !empty;
    pop        = wb_valid && wb_ready;
    // A full FIFO can still accept when the head leaves on the same edge.
    push_ok    = mul_complete && (!full || pop);
    go_ok      = go_in && can_issue;
    dec_ok     = mul_complete && (inflight != '0);
    err_set    = (go_in && !can_issue) ||
                 (mul_complete && full && !pop) ||
                 (mul_complete && (inflight == '0));
  end

  // Head payload; forced to zero while empty so stale storage never shows.
  always_comb begin
    wb_rob_ptr = '0;
    wb_prf_val = 1'b0;
    wb_prf_ptr = '0;
    wb_data    = '0;
    if (wb_valid) begin
      wb_rob_ptr = rob_mem[rd_idx];
      wb_prf_val = pv_mem[rd_idx];
      wb_prf_ptr = prf_mem[rd_idx];
      wb_data    = y_mem[rd_idx];
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rob_mem[wr_idx] <= mul_rob_ptr;
      pv_mem[wr_idx]  <= mul_prf_val;
      prf_mem[wr_idx] <= mul_prf_ptr;
      y_mem[wr_idx]   <= mul_y;
    end
  end

  // Pointer, credit and error-flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight     <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      // An illegal go is not counted; a spurious complete saturates at zero.
      if (go_ok && !dec_ok)      inflight <= inflight + 1'b1;
      else if (!go_ok && dec_ok) inflight <= inflight - 1'b1;
      if (err_set) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Bench for mul_wb_buffer: a behavioural 4-stage multiplier feeds the DUT, and a
// scoreboard queue holds the expected writeback stream in completion order.
module tb_mul_wb_buffer;

  localparam int M_WIDTH  = 64;
  localparam int LG_ROB   = 6;
  localparam int LG_PRF   = 7;
  localparam int LG_DEPTH = 3;
  localparam int DEPTH    = 8;
  localparam int MUL_LAT  = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               go_in = 1'b0;
  logic               mul_complete = 1'b0;
  logic [LG_ROB-1:0]  mul_rob_ptr = '0;
  logic               mul_prf_val = 1'b0;
  logic [LG_PRF-1:0]  mul_prf_ptr = '0;
  logic [M_WIDTH-1:0] mul_y = '0;
  logic               can_issue;
  logic               wb_valid;
  logic               wb_ready = 1'b0;
  logic [LG_ROB-1:0]  wb_rob_ptr;
  logic               wb_prf_val;
  logic [LG_PRF-1:0]  wb_prf_ptr;
  logic [M_WIDTH-1:0] wb_data;
  logic [LG_DEPTH:0]  occupancy;
  logic               err_overflow;

  typedef struct {
    int                 due;
    logic [LG_ROB-1:0]  rob;
    logic               pv;
    logic [LG_PRF-1:0]  prf;
    logic [M_WIDTH-1:0] y;
  } rec_t;

  rec_t pend[$];
  rec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  logic [LG_ROB-1:0]  next_rob = '0;
  logic               next_pv = 1'b1;
  logic [LG_PRF-1:0]  next_prf = '0;
  logic [M_WIDTH-1:0] next_y = '0;

  mul_wb_buffer #(
    .M_WIDTH(M_WIDTH), .LG_ROB(LG_ROB), .LG_PRF(LG_PRF), .LG_DEPTH(LG_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .go_in(go_in), .mul_complete(mul_complete),
    .mul_rob_ptr(mul_rob_ptr), .mul_prf_val(mul_prf_val), .mul_prf_ptr(mul_prf_ptr),
    .mul_y(mul_y), .can_issue(can_issue), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rob_ptr(wb_rob_ptr), .wb_prf_val(wb_prf_val), .wb_prf_ptr(wb_prf_ptr),
    .wb_data(wb_data), .occupancy(occupancy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic new_payload();
    next_pv  = 1'($urandom);
    next_prf = 7'($urandom);
    next_y   = {$urandom, $urandom};
  endtask

  // Reset asserted in the current cycle and held across one edge.
  task automatic do_reset();
    reset = 1'b1;
    go_in = 1'b0;
    mul_complete = 1'b0;
    wb_ready = 1'b0;
    pend.delete();
    sb.delete();
    next_rob = '0;
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
  endtask

  // One clock: go = 0 none, 1 tracked issue, 2 issue ignoring credits (not tracked);
  // spur injects a completion with no matching issue. Scoreboard pops are checked here.
  task automatic cycle(input int go, input bit rdy, input bit spur);
    rec_t r, exp_r;
    int   occ0;
    bit   has, pop;
    @(posedge clk); #1;
    cyc++;
    occ0 = sb.size();
    go_in = (go != 0);
    if (go == 1) begin
      r.due = cyc + MUL_LAT + 1;
      r.rob = next_rob; r.pv = next_pv; r.prf = next_prf; r.y = next_y;
      pend.push_back(r);
      next_rob++;
      new_payload();
    end
    wb_ready = rdy;
    has = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      has = 1;
    end else if (spur) begin
      r.due = cyc;
      r.rob = next_rob; r.pv = next_pv; r.prf = next_prf; r.y = next_y;
      next_rob++;
      new_payload();
      has = 1;
    end
    mul_complete = has;
    mul_rob_ptr  = has ? r.rob : '0;
    mul_prf_val  = has ? r.pv : 1'b0;
    mul_prf_ptr  = has ? r.prf : '0;
    mul_y        = has ? r.y : '0;
    n_cmp++;
    if (wb_valid !== (occ0 > 0)) begin
      n_bad++;
      $display("FAIL wb_valid cyc=%0d: got %b want %b", cyc, wb_valid, occ0 > 0);
    end
    pop = (occ0 > 0) && rdy;
    if (pop) begin
      exp_r = sb.pop_front();
      n_cmp++;
      if (wb_rob_ptr !== exp_r.rob || wb_prf_val !== exp_r.pv ||
          wb_prf_ptr !== exp_r.prf || wb_data !== exp_r.y) begin
        n_bad++;
        $display("FAIL wb_head cyc=%0d: got rob=%0d pv=%b prf=%0d y=%h want rob=%0d pv=%b prf=%0d y=%h",
                 cyc, wb_rob_ptr, wb_prf_val, wb_prf_ptr, wb_data,
                 exp_r.rob, exp_r.pv, exp_r.prf, exp_r.y);
      end
    end
    if (has && (occ0 < DEPTH || pop)) sb.push_back(r);
  endtask

  task automatic fill8();
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
    for (int i = 0; i < MUL_LAT + 2; i++) cycle(0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wb_valid !== 1'b0 || occupancy !== 4'd0 || can_issue !== 1'b1 || err_overflow !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle: got v=%b occ=%0d ci=%b err=%b want 0 0 1 0",
                 wb_valid, occupancy, can_issue, err_overflow);
      end
      n_cmp++;
      if (wb_rob_ptr !== '0 || wb_prf_val !== 1'b0 || wb_prf_ptr !== '0 || wb_data !== '0) begin
        n_bad++;
        $display("FAIL reset_payload: got rob=%0d pv=%b prf=%0d y=%h want zeros",
                 wb_rob_ptr, wb_prf_val, wb_prf_ptr, wb_data);
      end
      cycle(0, 1, 0);
    end
  endtask

  task automatic test_single();
    do_reset();
    next_rob = 6'd5; next_prf = 7'd17; next_pv = 1'b1; next_y = 64'hDEAD;
    cycle(1, 1, 0);
    for (int i = 0; i < MUL_LAT; i++) cycle(0, 1, 0);
    cycle(0, 1, 0);
    n_cmp++;
    if (mul_complete !== 1'b1 || wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_latency: got complete=%b wb_valid=%b want 1 0", mul_complete, wb_valid);
    end
    cycle(0, 1, 0);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_rob_ptr !== 6'd5 || wb_prf_ptr !== 7'd17 || wb_data !== 64'hDEAD) begin
      n_bad++;
      $display("FAIL single_fields: got v=%b rob=%0d prf=%0d y=%h want 1 5 17 dead",
               wb_valid, wb_rob_ptr, wb_prf_ptr, wb_data);
    end
    cycle(0, 1, 0);
    n_cmp++;
    if (occupancy !== 4'd0) begin
      n_bad++;
      $display("FAIL single_drained: got occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 0);
      n_cmp++;
      if (can_issue !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_credit go %0d: got can_issue=%b want 1", i, can_issue);
      end
    end
    cycle(0, 0, 0);
    n_cmp++;
    if (can_issue !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_no_credit: got can_issue=%b want 0", can_issue);
    end
    for (int i = 0; i < MUL_LAT + 1; i++) cycle(0, 0, 0);
    n_cmp++;
    if (occupancy !== 4'd8 || err_overflow !== 1'b0 || can_issue !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_full: got occ=%0d err=%b ci=%b want 8 0 0", occupancy, err_overflow, can_issue);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0);
      n_cmp++;
      if (wb_rob_ptr !== 6'(i)) begin
        n_bad++;
        $display("FAIL b2b_order: got rob=%0d want %0d", wb_rob_ptr, i);
      end
    end
    cycle(0, 0, 0);
    n_cmp++;
    if (occupancy !== 4'd0 || can_issue !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_empty: got occ=%0d ci=%b want 0 1", occupancy, can_issue);
    end
  endtask

  // Full FIFO with push+pop on the same edge; the extra pushes have no credit so
  // they also flag err_overflow as spurious completions.
  task automatic test_full_push_pop();
    do_reset();
    fill8();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1);
      n_cmp++;
      if (occupancy !== 4'd8) begin
        n_bad++;
        $display("FAIL fullpp_occ step %0d: got occ=%0d want 8", i, occupancy);
      end
    end
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    n_cmp++;
    if (occupancy !== 4'd0 || sb.size() != 0 || err_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL fullpp_end: got occ=%0d err=%b want 0 1 (scoreboard left %0d)",
               occupancy, err_overflow, sb.size());
    end
  endtask

  task automatic test_errors();
    do_reset();
    fill8();
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clean: got err=%b want 0", err_overflow);
    end
    cycle(2, 0, 0);
    cycle(0, 0, 0);
    n_cmp++;
    if (err_overflow !== 1'b1 || occupancy !== 4'd8) begin
      n_bad++;
      $display("FAIL err_go: got err=%b occ=%0d want 1 8", err_overflow, occupancy);
    end
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    n_cmp++;
    if (occupancy !== 4'd8 || can_issue !== 1'b0) begin
      n_bad++;
      $display("FAIL err_drop: got occ=%0d ci=%b want 8 0", occupancy, can_issue);
    end
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    n_cmp++;
    if (occupancy !== 4'd0 || err_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got occ=%0d err=%b want 0 1", occupancy, err_overflow);
    end
    do_reset();
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL err_cleared: got err=%b want 0", err_overflow);
    end
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    n_cmp++;
    if (err_overflow !== 1'b1 || occupancy !== 4'd1 || can_issue !== 1'b1) begin
      n_bad++;
      $display("FAIL err_spurious: got err=%b occ=%0d ci=%b want 1 1 1", err_overflow, occupancy, can_issue);
    end
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    n_cmp++;
    if (occupancy !== 4'd0) begin
      n_bad++;
      $display("FAIL err_spur_drain: got occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    n_cmp++;
    if (occupancy !== 4'd3 || can_issue !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_before: got occ=%0d ci=%b want 3 1", occupancy, can_issue);
    end
    do_reset();
    n_cmp++;
    if (wb_valid !== 1'b0 || occupancy !== 4'd0 || can_issue !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_after: got v=%b occ=%0d ci=%b want 0 0 1", wb_valid, occupancy, can_issue);
    end
    // Credits must be fully restored: eight fresh issues fit, a ninth does not.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    n_cmp++;
    if (can_issue !== 1'b0 || err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_credits: got ci=%b err=%b want 0 0", can_issue, err_overflow);
    end
    for (int i = 0; i < MUL_LAT + 1; i++) cycle(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0);
  endtask

  initial begin
    new_payload();
    test_reset();
    test_single();
    test_back_to_back();
    test_full_push_pop();
    test_errors();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
